// File: rtl/uart_pgm_loader.sv
// UART (8N1) boot loader: receives a framed program image and writes 16-bit words
// into RAM through the programming port (pgm / pgm_addr / pgm_data / pg_wr).
module uart_pgm_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [15:0] ADDR_BASE    = 16'h0000,
  parameter int unsigned WR_HIGH      = 4,
  parameter int unsigned WR_LOW       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        pgm,
  output logic [15:0] pgm_addr,
  output logic [15:0] pgm_data,
  output logic        pg_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("uart_pgm_loader: CLKS_PER_BIT must be at least 8");
  end
  if (WR_HIGH < 2 || WR_LOW < 2) begin : g_bad_wr
    $error("uart_pgm_loader: WR_HIGH and WR_LOW must be at least 2");
  end
  if (WR_HIGH + WR_LOW >= 10 * CLKS_PER_BIT) begin : g_bad_ratio
    $error("uart_pgm_loader: write cycle must be shorter than one UART byte");
  end

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned WCNT_W = $clog2(WR_HIGH + WR_LOW + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [WCNT_W-1:0] WH_LAST   = WCNT_W'(WR_HIGH - 1);
  localparam logic [WCNT_W-1:0] WL_END    = WCNT_W'(WR_LOW);
  localparam logic [7:0]        SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WR_PULSE, S_WR_GAP, S_CHK, S_DONE, S_ERR
  } state_e;

  // ---------------- receiver ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid, frame_err;

  // NOTE: sequential state is updated with non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = RX_IDLE;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Holding register also carries framing errors so they are acted on in byte order.
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d, hold_ferr_q, hold_ferr_d;
  logic       consume;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q && !consume;
    hold_ferr_d = hold_ferr_q;
    if (byte_valid) begin
      hold_d      = rx_shift_q;
      hold_full_d = 1'b1;
      hold_ferr_d = 1'b0;
    end else if (frame_err) begin
      hold_full_d = 1'b1;
      hold_ferr_d = 1'b1;
    end
  end

  // ---------------- loader FSM ----------------
  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d, idx_q, idx_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]        chk_q, chk_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              pgm_q, pgm_d, pg_wr_q, pg_wr_d, busy_q, busy_d;
  logic              done_q, done_d, err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      hold_ferr_q <= 1'b0;
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      wcnt_q      <= '0;
      pgm_q       <= 1'b0;
      pg_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      hold_ferr_q <= hold_ferr_d;
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      wcnt_q      <= wcnt_d;
      pgm_q       <= pgm_d;
      pg_wr_q     <= pg_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    chk_d   = chk_q;
    wcnt_d  = wcnt_q;
    pgm_d   = pgm_q;
    busy_d  = busy_q;
    err_d   = err_q;
    pg_wr_d = 1'b0;
    done_d  = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          consume = 1'b1;
          if (!hold_ferr_q && hold_q == SYNC_BYTE) begin
            err_d   = 1'b0;
            busy_d  = 1'b1;
            pgm_d   = 1'b1;
            len_d   = '0;
            idx_d   = '0;
            chk_d   = '0;
            addr_d  = ADDR_BASE;
            state_d = S_LEN_HI;
          end
        end
      end
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: begin
        if (hold_full_q) begin
          consume = 1'b1;
          if (hold_ferr_q) begin
            state_d = S_ERR;
          end else begin
            unique case (state_q)
              S_LEN_HI: begin
                len_d   = {hold_q, len_q[7:0]};
                state_d = S_LEN_LO;
              end
              S_LEN_LO: begin
                len_d   = {len_q[15:8], hold_q};
                state_d = (len_d == 16'd0) ? S_CHK : S_DATA_HI;
              end
              S_DATA_HI: begin
                data_d  = {hold_q, data_q[7:0]};
                chk_d   = chk_q ^ hold_q;
                state_d = S_DATA_LO;
              end
              S_DATA_LO: begin
                data_d  = {data_q[15:8], hold_q};
                chk_d   = chk_q ^ hold_q;
                wcnt_d  = '0;
                state_d = S_WR_PULSE;
              end
              default: state_d = (hold_q == chk_q) ? S_DONE : S_ERR;
            endcase
          end
        end
      end
      S_WR_PULSE: begin
        // pg_wr is registered, so it trails this state by one cycle: address and
        // data latched in DATA_LO are stable a cycle before the rising edge.
        pg_wr_d = 1'b1;
        if (wcnt_q == WH_LAST) begin
          wcnt_d  = '0;
          state_d = S_WR_GAP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WR_GAP: begin
        if (wcnt_q == WL_END) begin
          idx_d   = idx_q + 16'd1;
          addr_d  = addr_q + 16'd1;
          state_d = (idx_d == len_q) ? S_CHK : S_DATA_HI;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pgm_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        pgm_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pgm      = pgm_q;
  assign pgm_addr = addr_q;
  assign pgm_data = data_q;
  assign pg_wr    = pg_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/uart_pgm_loader.md
Name: uart_pgm_loader

Overview:
Serial boot loader sitting directly upstream of the RAM programming port. Receives a framed program image over UART (8N1) and drives pgm, pgm_addr, pgm_data and pg_wr to write 16-bit words into RAM. It holds pgm high for the whole load so internal CPU writes are blocked, then releases it and flags completion or error.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit; minimum 8.
ADDR_BASE, 16'h0000, RAM address of the first loaded word.
WR_HIGH, 4, cycles pg_wr is held high per word; minimum 2.
WR_LOW, 4, cycles pg_wr is held low after each pulse; minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx  in  1  UART receive line, idle high, asynchronous to clk
pgm  out  1  high while a frame is being loaded
pgm_addr  out  16  RAM address for the current word
pgm_data  out  16  word to write
pg_wr  out  1  write strobe; RAM acts on its rising edge
busy  out  1  high from sync byte accepted until DONE or ERR
done  out  1  one-cycle pulse on successful load
err  out  1  sticky; set on checksum mismatch or framing error; cleared by rst or next sync byte

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; receiver goes to idle; word counter, checksum and holding byte are cleared. A reset in the middle of a load abandons the frame, drops pgm the next cycle and performs no further writes.
- RX front end:
  - rx passes through a 2-flop synchroniser (reset value 1).
  - A start bit is a falling edge that is still low at half of CLKS_PER_BIT.
  - Each data bit is sampled at mid-bit, LSB first.
  - If the stop bit samples 0, that is a framing error: the byte is discarded.
  - A valid byte raises byte_valid for one cycle and is stored in a 1-byte holding register.
- Frame format: 0xA5 sync, LEN_HI, LEN_LO (word count N), then N words each sent high byte first, then CHK, the XOR of every data byte.
- FSM states and transitions:
  - IDLE: any byte other than 0xA5 is ignored. 0xA5 clears err, sets busy and goes to LEN_HI.
  - LEN_HI, LEN_LO: latch N. If N==0, skip to CHK.
  - On entry to LEN_HI or after LEN_LO, pgm goes high. pgm stays high until DONE or ERR.
  - DATA_HI: latch pgm_data[15:8]. DATA_LO: latch pgm_data[7:0].
  - After DATA_LO, go to WR_PULSE.
  - WR_PULSE: pg_wr high for WR_HIGH cycles, then go to WR_GAP.
  - WR_GAP: pg_wr low for WR_LOW cycles. Then increment the word index. If the index equals N go to CHK, else go to DATA_HI.
  - CHK: if the byte equals the accumulated XOR go to DONE, otherwise go to ERR.
  - DONE: pulse done for one cycle, drop pgm and busy, return to IDLE.
  - ERR: set err, drop pgm and busy, return to IDLE.
- Timing of address and data: pgm_addr = ADDR_BASE + index, 16-bit wrap-around with no error at the wrap. pgm_addr and pgm_data are stable from one cycle before pg_wr rises until the end of WR_GAP.
- pgm rises at least 1 cycle before the first pg_wr rising edge. pgm falls no earlier than WR_LOW cycles after the last pg_wr falling edge.
- Bytes arriving during WR_PULSE or WR_GAP are kept in the holding register and consumed on return to DATA_HI.
  - WR_HIGH+WR_LOW must be less than 10*CLKS_PER_BIT; this is guaranteed by parameter checks, so no overrun is possible.
- A framing error in any non-IDLE state goes to ERR; writes already performed are not undone. A framing error in IDLE is ignored.
- Words already written remain in RAM on a checksum error; err is the only indication.
- Pulse widths: pg_wr is never high for fewer than WR_HIGH cycles, and each pulse produces exactly one rising edge.

Test Plan:
1. CLKS_PER_BIT=8. Send A5 00 02 12 34 AB CD, CHK=0x40 -> two pg_wr pulses at addr 0x0000 data 0x1234 and addr 0x0001 data 0xABCD; done pulses once; err=0; pgm low after done.
2. Same frame with CHK=0x41 -> both writes occur, err=1 and stays 1, done never pulses, pgm drops.
3. Send A5 00 00 00 -> no pg_wr pulse, done=1, err=0.
4. Send 0x55 0x00 then a valid one-word frame -> the leading bytes are ignored, exactly one write occurs, done=1.
5. Assert rst during the high phase of the 2nd word's pg_wr in a 3-word frame -> next cycle all outputs are 0 and no further pulses occur. A fresh frame then loads correctly starting at ADDR_BASE.
6. ADDR_BASE=16'hFFFF, frame of 2 words -> writes go to 0xFFFF then 0x0000. Separately, a stop bit forced to 0 mid-frame -> err=1, pgm=0, busy=0.
